cache_ctrl: RTL
===============

# cache_ctrl

Clocked controller for the 2-way set-associative, write-through cache (4 blocks × 128 bit, 10-bit byte address, 5-bit tag, 1-bit set index, 4-bit byte offset). It owns the tag, valid, LRU and data arrays. It sequences every CPU access through lookup, line fill, write-through and response, using a req/ack handshake to main memory. It sits between the CPU load/store port and the main-memory model.

## Interface
- ADDR_W, 10, byte address width
- BLOCK_W, 128, line width in bits
- TAG_W, 5, tag width (addr[9:5])
- BYTE, 8, data byte width
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cpu_req  in  1  CPU request valid
- cpu_row  in  1  1 = write, 0 = read
- cpu_addr  in  10  byte address: tag [9:5], set [4], offset [3:0]
- cpu_wdata  in  8  write byte
- cpu_ready  out  1  one-cycle completion pulse
- cpu_rdata  out  8  read byte, valid with cpu_ready
- hit_or_miss  out  1  1 = hit, 0 = miss, valid with cpu_ready
- mem_req  out  1  memory request
- mem_row  out  1  1 = block write, 0 = block read
- mem_addr  out  10  block-aligned address ({tag, set, 4'b0})
- mem_wdata  out  128  full line for write-through
- mem_rdata  in  128  fill data, valid in the mem_ack cycle
- mem_ack  in  1  memory completion, one cycle

## Operation
- **States:** IDLE, LOOKUP, FILL, WTHRU, RESP.
- **IDLE:** if cpu_req=1, latch addr/row/wdata and go to LOOKUP. Otherwise stay in IDLE.
- **LOOKUP:** compare the latched tag against both ways of set addr[4]. Hit requires valid && tag match; way 0 is checked first.
  - Read hit → RESP.
  - Write hit → merge byte at offset\*8 into the line, then WTHRU.
  - Miss → FILL.
- **FILL:** mem_req=1, mem_row=0, mem_addr=block address. On mem_ack:
  - Write mem_rdata into the victim way, set its tag and valid bit.
  - Write miss → merge byte, then WTHRU. Read miss → RESP.
- **Victim selection:** first invalid way (way 0 first); if both are valid, the way named by lru[set].
- **WTHRU:** mem_req=1, mem_row=1, mem_wdata = updated line. On mem_ack → RESP.
- **RESP:** cpu_ready=1 for one cycle. cpu_rdata = the addressed byte (the new byte for writes). hit_or_miss = the LOOKUP result. Then IDLE.
- **LRU:** one bit per set. On every hit or fill to way w, lru[set] = ~w.
- **Write policy:** write-through with write-allocate. Memory is always up to date, so eviction never writes back.
- cpu_req is ignored outside IDLE; there is no queuing.

## Timing
- **Reset values:** cpu_ready=0, cpu_rdata=0, hit_or_miss=0, mem_req=0, mem_row=0, mem_addr=0, mem_wdata=0. All valid bits=0, lru=0, state=IDLE. The data array is not reset; valid gates it.
- Reset is asynchronous. Assertion mid-operation aborts immediately: mem_req drops without waiting for the clock, and a partially filled line stays invalid.
- **Latency** (counted from the accept edge, request sampled in IDLE):
  - Read hit: cpu_ready 2 cycles later.
  - Miss or write: 2 cycles + memory wait + 1 cycle per memory transaction.
- **Memory handshake:**
  - mem_req, mem_row, mem_addr and mem_wdata stay stable until mem_ack is sampled high.
  - mem_req deasserts on the next edge.
  - Write miss: the FILL-to-WTHRU transition deasserts mem_req for at least 1 cycle.
  - mem_ack while mem_req=0 is ignored.
  - Zero-wait memory (mem_ack in the first mem_req cycle) is legal.
- **CPU handshake:**
  - cpu_req still high in the IDLE cycle after RESP is a new, back-to-back request.
  - The requester must drop cpu_req in the cycle after cpu_ready unless it is issuing another access.

## Structure
- Package cache_pkg: width parameters, state enum, and field helpers get_tag/get_set/get_off/block_addr.
- Sub-module cache_tag_array: tags, valid and LRU storage. It provides combinational hit/hit_way/victim_way outputs plus a synchronous fill/touch update port. The FSM and data array stay in cache_ctrl.

## Test plan
1. **Cold read miss:** after reset, read 0x123.
   - Expect mem_req with mem_row=0, mem_addr=0x120.
   - Ack after 3 cycles with byte 3 = 0xA5.
   - Expect cpu_ready with hit_or_miss=0, cpu_rdata=0xA5.
2. **Read hit:** then read 0x12F.
   - Expect no mem_req, cpu_ready 2 cycles after accept, hit_or_miss=1, cpu_rdata = byte 15 of the filled line.
3. **Write hit:** write 0x125 with 0x3C.
   - Expect mem_req with mem_row=1, mem_addr=0x120, mem_wdata byte 5 = 0x3C and all other bytes unchanged.
   - After ack: hit_or_miss=1. A subsequent read of 0x125 returns 0x3C.
4. **LRU eviction:** fill 0x020 (set 0 → way 1), read 0x123 (touch way 0), then read 0x040.
   - Expect way 1 evicted. Then 0x020 misses and 0x123 hits.
5. **Write miss:** write 0x3F1 with 0x77.
   - Expect a fill from 0x3F0, then a write-through to 0x3F0 with byte 1 = 0x77.
   - Expect hit_or_miss=0.
6. **Reset during FILL wait:** assert rst_n=0 while waiting in FILL.
   - Expect mem_req=0 and cpu_ready=0 immediately.
   - After release, reading the same address misses again.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared widths, controller state encoding and address field helpers
// for the 2-way set-associative write-through cache.
package cache_pkg;

    localparam int ADDR_W  = 10;
    localparam int BLOCK_W = 128;
    localparam int TAG_W   = 5;
    localparam int BYTE    = 8;
    localparam int OFF_W   = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        FILL,
        WTHRU,
        RESP
    } state_t;

    function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic get_set(input logic [ADDR_W-1:0] addr);
        return addr[OFF_W];
    endfunction

    function automatic logic [OFF_W-1:0] get_off(input logic [ADDR_W-1:0] addr);
        return addr[OFF_W-1:0];
    endfunction

    function automatic logic [ADDR_W-1:0] block_addr(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    endfunction

endpackage

// File: rtl/cache_tag_array.sv
// Tag, valid and LRU storage for both sets. Lookup is combinational on the
// presented set/tag; fills and hit touches update on the rising edge.
module cache_tag_array
    import cache_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set,
    input  logic [TAG_W-1:0] tag,
    input  logic             fill_en,
    input  logic             touch_en,
    input  logic             way,
    output logic             hit,
    output logic             hit_way,
    output logic             victim_way
);

    // Entries are indexed {set, way}; tags are meaningless until valid is set.
    logic [TAG_W-1:0] tag_mem [4];
    logic [3:0]       valid;
    logic [1:0]       lru;
    logic             hit0;
    logic             hit1;

    // Way 0 wins on a hit; victim is the first invalid way, else the LRU way.
    always_comb begin
        hit0       = valid[{set, 1'b0}] && (tag_mem[{set, 1'b0}] == tag);
        hit1       = valid[{set, 1'b1}] && (tag_mem[{set, 1'b1}] == tag);
        hit        = hit0 || hit1;
        hit_way    = !hit0;
        victim_way = lru[set];
        if (!valid[{set, 1'b0}]) begin
            victim_way = 1'b0;
        end else if (!valid[{set, 1'b1}]) begin
            victim_way = 1'b1;
        end
    end

    // Valid bits and LRU: a fill validates the way, any use points LRU at the other way.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
            lru   <= '0;
        end else begin
            if (fill_en) begin
                valid[{set, way}] <= 1'b1;
            end
            if (fill_en || touch_en) begin
                lru[set] <= ~way;
            end
        end
    end

    // Tag storage is gated by valid, so it needs no reset.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag_mem[{set, way}] <= tag;
        end
    end

endmodule

// File: rtl/cache_ctrl.sv
// Cache controller: sequences each CPU access through lookup, line fill,
// write-through and response, and owns the line data array.
module cache_ctrl
    import cache_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cpu_req,
    input  logic               cpu_row,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic [BYTE-1:0]    cpu_wdata,
    output logic               cpu_ready,
    output logic [BYTE-1:0]    cpu_rdata,
    output logic               hit_or_miss,
    output logic               mem_req,
    output logic               mem_row,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [BLOCK_W-1:0] mem_wdata,
    input  logic [BLOCK_W-1:0] mem_rdata,
    input  logic               mem_ack
);

    state_t             state;
    state_t             state_next;
    logic [ADDR_W-1:0]  addr_q;
    logic               row_q;
    logic [BYTE-1:0]    wdata_q;
    logic               hit_q;
    logic               way_q;
    logic [BLOCK_W-1:0] data_mem [4];
    logic               hit;
    logic               hit_way;
    logic               victim_way;
    logic               ack;
    logic               fill_en;
    logic               touch_en;
    logic               tag_way;
    logic [1:0]         hit_idx;
    logic [1:0]         way_idx;
    logic [BLOCK_W-1:0] hit_line;

    function automatic logic [BLOCK_W-1:0] merge_byte(input logic [BLOCK_W-1:0] line,
                                                      input logic [OFF_W-1:0]   off,
                                                      input logic [BYTE-1:0]    b);
        logic [BLOCK_W-1:0] r;
        r = line;
        r[off*BYTE +: BYTE] = b;
        return r;
    endfunction

    function automatic logic [BYTE-1:0] pick_byte(input logic [BLOCK_W-1:0] line,
                                                  input logic [OFF_W-1:0]   off);
        return line[off*BYTE +: BYTE];
    endfunction

    // An ack only counts while a request is actually outstanding.
    assign ack      = mem_req && mem_ack;
    assign touch_en = (state == LOOKUP) && hit;
    assign fill_en  = (state == FILL) && ack;
    assign tag_way  = (state == LOOKUP) ? hit_way : way_q;
    assign hit_idx  = {get_set(addr_q), hit_way};
    assign way_idx  = {get_set(addr_q), way_q};
    assign hit_line = data_mem[hit_idx];

    cache_tag_array u_tags (
        .clk        (clk),
        .rst_n      (rst_n),
        .set        (get_set(addr_q)),
        .tag        (get_tag(addr_q)),
        .fill_en    (fill_en),
        .touch_en   (touch_en),
        .way        (tag_way),
        .hit        (hit),
        .hit_way    (hit_way),
        .victim_way (victim_way)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (cpu_req) state_next = LOOKUP;
            LOOKUP:  state_next = hit ? (row_q ? WTHRU : RESP) : FILL;
            FILL:    if (ack) state_next = row_q ? WTHRU : RESP;
            WTHRU:   if (ack) state_next = RESP;
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Registered CPU/memory outputs; WTHRU entered from FILL spends its first
    // cycle with mem_req low, giving the required gap between transactions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_ready   <= 1'b0;
            cpu_rdata   <= '0;
            hit_or_miss <= 1'b0;
            mem_req     <= 1'b0;
            mem_row     <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            hit_q       <= 1'b0;
            way_q       <= 1'b0;
        end else begin
            cpu_ready <= 1'b0;
            case (state)
                LOOKUP: begin
                    hit_q <= hit;
                    way_q <= hit ? hit_way : victim_way;
                    if (!hit) begin
                        mem_req  <= 1'b1;
                        mem_row  <= 1'b0;
                        mem_addr <= block_addr(addr_q);
                    end else if (row_q) begin
                        mem_req   <= 1'b1;
                        mem_row   <= 1'b1;
                        mem_addr  <= block_addr(addr_q);
                        mem_wdata <= merge_byte(hit_line, get_off(addr_q), wdata_q);
                    end else begin
                        cpu_ready   <= 1'b1;
                        cpu_rdata   <= pick_byte(hit_line, get_off(addr_q));
                        hit_or_miss <= 1'b1;
                    end
                end
                FILL: begin
                    if (ack) begin
                        mem_req <= 1'b0;
                        if (!row_q) begin
                            cpu_ready   <= 1'b1;
                            cpu_rdata   <= pick_byte(mem_rdata, get_off(addr_q));
                            hit_or_miss <= hit_q;
                        end
                    end
                end
                WTHRU: begin
                    if (!mem_req) begin
                        mem_req   <= 1'b1;
                        mem_row   <= 1'b1;
                        mem_addr  <= block_addr(addr_q);
                        mem_wdata <= data_mem[way_idx];
                    end else if (mem_ack) begin
                        mem_req     <= 1'b0;
                        cpu_ready   <= 1'b1;
                        cpu_rdata   <= wdata_q;
                        hit_or_miss <= hit_q;
                    end
                end
                default: ;
            endcase
        end
    end

    // Request latch and line data; valid bits gate the data, so none is reset.
    always_ff @(posedge clk) begin
        if (state == IDLE && cpu_req) begin
            addr_q  <= cpu_addr;
            row_q   <= cpu_row;
            wdata_q <= cpu_wdata;
        end
        if (touch_en && row_q) begin
            data_mem[hit_idx] <= merge_byte(hit_line, get_off(addr_q), wdata_q);
        end
        if (fill_en) begin
            data_mem[way_idx] <= row_q ? merge_byte(mem_rdata, get_off(addr_q), wdata_q) : mem_rdata;
        end
    end

endmodule
